// File: rtl/morse_pkg.sv
// Shared definitions for the Morse encoder: FSM states, character code ranges,
// and the pattern/length table used by the code ROM.
// Each table entry is {pattern[4:0], len[2:0]}. A 1 bit is a dash and a 0 bit is a dot.
// The first element sits at bit len-1, and unused upper bits are 0.
package morse_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MARK = 2'd1,
        GAP  = 2'd2,
        CGAP = 2'd3
    } state_t;

    localparam logic [5:0] CODE_DIGIT_BASE = 6'd0;
    localparam logic [5:0] CODE_ALPHA_BASE = 6'd10;
    localparam logic [5:0] CODE_MAX        = 6'd35;

    localparam logic [7:0] MORSE_TABLE [0:35] = '{
        {5'b11111, 3'd5},  // 0 -----
        {5'b01111, 3'd5},  // 1 .----
        {5'b00111, 3'd5},  // 2 ..---
        {5'b00011, 3'd5},  // 3 ...--
        {5'b00001, 3'd5},  // 4 ....-
        {5'b00000, 3'd5},  // 5 .....
        {5'b10000, 3'd5},  // 6 -....
        {5'b11000, 3'd5},  // 7 --...
        {5'b11100, 3'd5},  // 8 ---..
        {5'b11110, 3'd5},  // 9 ----.
        {5'b00001, 3'd2},  // A .-
        {5'b01000, 3'd4},  // B -...
        {5'b01010, 3'd4},  // C -.-.
        {5'b00100, 3'd3},  // D -..
        {5'b00000, 3'd1},  // E .
        {5'b00010, 3'd4},  // F ..-.
        {5'b00110, 3'd3},  // G --.
        {5'b00000, 3'd4},  // H ....
        {5'b00000, 3'd2},  // I ..
        {5'b00111, 3'd4},  // J .---
        {5'b00101, 3'd3},  // K -.-
        {5'b00100, 3'd4},  // L .-..
        {5'b00011, 3'd2},  // M --
        {5'b00010, 3'd2},  // N -.
        {5'b00111, 3'd3},  // O ---
        {5'b00110, 3'd4},  // P .--.
        {5'b01101, 3'd4},  // Q --.-
        {5'b00010, 3'd3},  // R .-.
        {5'b00000, 3'd3},  // S ...
        {5'b00001, 3'd1},  // T -
        {5'b00001, 3'd3},  // U ..-
        {5'b00001, 3'd4},  // V ...-
        {5'b00011, 3'd3},  // W .--
        {5'b01001, 3'd4},  // X -..-
        {5'b01011, 3'd4},  // Y -.--
        {5'b01100, 3'd4}   // Z --..
    };

endpackage

// File: rtl/morse_code_rom.sv
// Combinational character-code lookup. It returns the Morse pattern, the element
// count, and whether the code is valid. Invalid codes (above CODE_MAX) return zeros.
import morse_pkg::*;

module morse_code_rom (
    input  logic [5:0] char_code,
    output logic [4:0] pattern,
    output logic [2:0] len,
    output logic       valid
);

    // Table lookup, gated by the valid code range
    always_comb begin
        valid   = (char_code <= CODE_MAX);
        pattern = 5'd0;
        len     = 3'd0;
        if (valid) begin
            {pattern, len} = MORSE_TABLE[char_code];
        end
    end

endmodule

// File: rtl/morse_encoder_tx.sv
// Morse code transmitter. On a rising edge of start it keys out one character
// as dots, dashes, element gaps and a trailing character gap.
// Optional build macro: MORSE_SOUND_EN. When defined, the buzzer is a
// TONE_HALF-divided square wave while keyed. When undefined, buzzer mirrors key_out.
import morse_pkg::*;

module morse_encoder_tx #(
    parameter int UNIT_CYCLES = 25000000,
    parameter int TONE_HALF   = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       start,
    input  logic [5:0] char_code,
    output logic       key_out,
    output logic       buzzer,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [4:0] led_morse,
    output logic [2:0] led_cnt
);

    if (UNIT_CYCLES < 2 || TONE_HALF < 1) begin : g_bad_params
        $error("morse_encoder_tx: UNIT_CYCLES must be >= 2 and TONE_HALF >= 1");
    end

    localparam logic [26:0] UNIT_LAST = 27'(UNIT_CYCLES - 1);
    localparam logic [26:0] DASH_LAST = 27'(3 * UNIT_CYCLES - 1);

    state_t      state, next_state;
    logic        s1, s2, request;
    logic [26:0] unit_cnt;
    logic [4:0]  rom_pattern;
    logic [2:0]  rom_len;
    logic        rom_valid;
    logic        elem_dash;
    logic        load, dec, cnt_clr, done_set, err_set;
    logic        key_next;

    morse_code_rom u_rom (
        .char_code (char_code),
        .pattern   (rom_pattern),
        .len       (rom_len),
        .valid     (rom_valid)
    );

    assign request   = s1 & ~s2;
    // The current element is the bit at position led_cnt-1 (the top of the remaining elements).
    assign elem_dash = |(led_morse & (5'b00001 << (led_cnt - 3'd1)));
    assign key_next  = en && (state == MARK);

    // Two-flop sampling of start for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= start;
            s2 <= s1;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state and control strobes. Requests outside IDLE are simply dropped.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        dec        = 1'b0;
        cnt_clr    = 1'b0;
        done_set   = 1'b0;
        err_set    = 1'b0;
        if (!en) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (request) begin
                        if (rom_valid) begin
                            load       = 1'b1;
                            cnt_clr    = 1'b1;
                            next_state = MARK;
                        end else begin
                            err_set = 1'b1;
                        end
                    end
                end
                MARK: begin
                    if (unit_cnt == (elem_dash ? DASH_LAST : UNIT_LAST)) begin
                        dec        = 1'b1;
                        cnt_clr    = 1'b1;
                        next_state = (led_cnt > 3'd1) ? GAP : CGAP;
                    end
                end
                GAP: begin
                    if (unit_cnt == UNIT_LAST) begin
                        cnt_clr    = 1'b1;
                        next_state = MARK;
                    end
                end
                CGAP: begin
                    if (unit_cnt == DASH_LAST) begin
                        cnt_clr    = 1'b1;
                        done_set   = 1'b1;
                        next_state = IDLE;
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    // Time-unit counter. It restarts at every state entry and stays at 0 in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                   unit_cnt <= 27'd0;
        else if (!en || cnt_clr || state == IDLE)  unit_cnt <= 27'd0;
        else                                       unit_cnt <= unit_cnt + 27'd1;
    end

    // Pattern and count display registers. led_morse holds across disable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_morse <= 5'd0;
            led_cnt   <= 3'd0;
        end else begin
            if (load) led_morse <= rom_pattern;
            if (!en)       led_cnt <= 3'd0;
            else if (load) led_cnt <= rom_len;
            else if (dec)  led_cnt <= led_cnt - 3'd1;
        end
    end

    // Status outputs. key_out is registered from the MARK state, so it lags it by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_out <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            key_out <= key_next;
            done    <= en && done_set;
            err     <= en && err_set;
            if (!en)           busy <= 1'b0;
            else if (load)     busy <= 1'b1;
            else if (done_set) busy <= 1'b0;
        end
    end

`ifdef MORSE_SOUND_EN
    logic [31:0] tone_cnt;

    // Tone divider. It starts high on each mark and toggles every TONE_HALF cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tone_cnt <= 32'd0;
            buzzer   <= 1'b0;
        end else if (!key_next) begin
            tone_cnt <= 32'd0;
            buzzer   <= 1'b0;
        end else if (!key_out) begin
            tone_cnt <= 32'd0;
            buzzer   <= 1'b1;
        end else if (tone_cnt == 32'(TONE_HALF - 1)) begin
            tone_cnt <= 32'd0;
            buzzer   <= ~buzzer;
        end else begin
            tone_cnt <= tone_cnt + 32'd1;
        end
    end
`else
    assign buzzer = key_out;
`endif

endmodule

// File: tb/tb_morse_encoder_tx.sv
// Directed testbench for morse_encoder_tx with UNIT_CYCLES=4 and TONE_HALF=1.
module tb_morse_encoder_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       start;
    logic [5:0] char_code;
    logic       key_out, buzzer, busy, done, err;
    logic [4:0] led_morse;
    logic [2:0] led_cnt;

    int checks   = 0;
    int failures = 0;

    logic [199:0] key_cap, busy_cap, done_cap, err_cap, buzz_cap;
    int           cnt_cap [200];

    morse_encoder_tx #(.UNIT_CYCLES(4), .TONE_HALF(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .start     (start),
        .char_code (char_code),
        .key_out   (key_out),
        .buzzer    (buzzer),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .led_morse (led_morse),
        .led_cnt   (led_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [199:0] span(input int from, input int len);
        logic [199:0] v;
        v = '0;
        for (int i = from; i < from + len; i++) v[i] = 1'b1;
        return v;
    endfunction

    // Sample i is taken at the falling edge after rising edge i+1 (counted from start being set).
    task automatic capture(input int n, input int repulse_at);
        key_cap = '0; busy_cap = '0; done_cap = '0; err_cap = '0; buzz_cap = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 2) start = 1'b0;
            if (i == repulse_at) begin start = 1'b1; char_code = 6'd11; end
            if (i == repulse_at + 2) start = 1'b0;
            key_cap[i]  = key_out;
            busy_cap[i] = busy;
            done_cap[i] = done;
            err_cap[i]  = err;
            buzz_cap[i] = buzzer;
            cnt_cap[i]  = int'(led_cnt);
        end
    endtask

    task automatic send(input logic [5:0] code);
        char_code = code;
        start     = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; start = 1'b0; char_code = 6'd0;
        idle(3);
        chk("reset_key",  200'(key_out), 200'(0));
        chk("reset_busy", 200'(busy), 200'(0));
        chk("reset_done_err", 200'({done, err, buzzer}), 200'(0));
        chk("reset_leds", 200'({led_morse, led_cnt}), 200'(0));
        rst = 1'b0;
        idle(2);

        // 'E' : one dot
        send(6'd14);
        capture(40, -10);
        chk("E_key",  key_cap,  span(2, 4));
        chk("E_busy", busy_cap, span(1, 16));
        chk("E_done", done_cap, span(17, 1));
`ifndef MORSE_SOUND_EN
        chk("E_buzzer", buzz_cap, key_cap);
`endif
        idle(3);

        // 'A' : dot dash
        send(6'd10);
        capture(50, -10);
        chk("A_key",  key_cap,  span(2, 4) | span(10, 12));
        chk("A_busy", busy_cap, span(1, 32));
        chk("A_done", done_cap, span(33, 1));
        chk("A_cnt1", 200'(cnt_cap[1]),  200'(2));
        chk("A_cnt4", 200'(cnt_cap[4]),  200'(2));
        chk("A_cnt5", 200'(cnt_cap[5]),  200'(1));
        chk("A_cnt20", 200'(cnt_cap[20]), 200'(1));
        chk("A_cnt21", 200'(cnt_cap[21]), 200'(0));
        chk("A_morse", 200'(led_morse), 200'(5'b00001));
        idle(3);

        // '0' : five dashes
        send(6'd0);
        capture(100, -10);
        chk("Z0_key", key_cap, span(2, 12) | span(18, 12) | span(34, 12) | span(50, 12) | span(66, 12));
        chk("Z0_busy", busy_cap, span(1, 88));
        chk("Z0_done", done_cap, span(89, 1));
        chk("Z0_cnt1", 200'(cnt_cap[1]), 200'(5));
        chk("Z0_morse", 200'(led_morse), 200'(5'b11111));
        idle(3);

        // invalid code 40
        send(6'd40);
        capture(20, -10);
        chk("inv_err",  err_cap,  span(1, 1));
        chk("inv_key",  key_cap,  200'(0));
        chk("inv_busy", busy_cap, 200'(0));
        chk("inv_done", done_cap, 200'(0));
        chk("inv_leds", 200'({led_morse, led_cnt}), 200'({5'b11111, 3'd0}));
        idle(3);

        // second request during the 'E' mark is ignored
        send(6'd14);
        capture(40, 3);
        chk("rep_key",  key_cap,  span(2, 4));
        chk("rep_done", done_cap, span(17, 1));
        chk("rep_busy", busy_cap, span(1, 16));
        chk("rep_morse", 200'(led_morse), 200'(5'b00000));
        idle(3);

        // reset in the middle of the dash of 'A'
        send(6'd10);
        capture(14, -10);
        chk("pre_rst_key", 200'(key_out), 200'(1));
        #1 rst = 1'b1;
        #1;
        chk("rst_key", 200'(key_out), 200'(0));
        chk("rst_outs", 200'({buzzer, busy, done, err}), 200'(0));
        chk("rst_leds", 200'({led_morse, led_cnt}), 200'(0));
        @(negedge clk);
        rst = 1'b0;
        idle(2);
        send(6'd14);
        capture(40, -10);
        chk("post_rst_E_key",  key_cap,  span(2, 4));
        chk("post_rst_E_done", done_cap, span(17, 1));
        idle(3);

        // disable in the middle of the first gap of 'A'
        send(6'd10);
        capture(8, -10);
        chk("pre_dis_cnt", 200'(led_cnt), 200'(1));
        en = 1'b0;
        capture(40, -10);
        chk("dis_key",  key_cap,  200'(0));
        chk("dis_busy", busy_cap, 200'(0));
        chk("dis_done", done_cap, 200'(0));
        chk("dis_cnt0", 200'(cnt_cap[0]), 200'(0));
        chk("dis_morse", 200'(led_morse), 200'(5'b00001));
        en = 1'b1;
        idle(2);
        send(6'd14);
        capture(40, -10);
        chk("post_dis_E_key",  key_cap,  span(2, 4));
        chk("post_dis_E_done", done_cap, span(17, 1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
